// File: rtl/timer_pkg.sv
// timer_pkg -- shared constants for the timer_cmp block.
//   Register word offsets, CTRL/STATUS bit positions, prescaler width and
//   a helper that maps a compare channel index to its word address.
package timer_pkg;

  localparam int PRE_W = 16;

  typedef enum logic [3:0] {
    REG_COUNT_LO = 4'd0,
    REG_COUNT_HI = 4'd1,
    REG_CTRL     = 4'd2,
    REG_STATUS   = 4'd3,
    REG_CMP_BASE = 4'd4
  } reg_addr_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IE_LSB     = 8;
  localparam int CTRL_PRE_LSB    = 16;
  localparam int STATUS_PEND_LSB = 0;

  // Word address of compare channel k: LO half at 4+2k, HI half at 5+2k.
  function automatic logic [3:0] cmp_addr(input int k, input logic hi);
    return 4'(int'(REG_CMP_BASE) + 2 * k + (hi ? 1 : 0));
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler -- divides the clock by (pre + 1) while enabled.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   en   : enable; the divider counter is held at 0 while low
//   pre  : terminal count; tick fires when the counter equals it
//   clr  : restart the divider counter from 0 (PRE was rewritten)
//   tick : one-cycle pulse, combinational from the current counter state
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PRE_W-1:0] pre,
  input  logic             clr,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;

  assign tick = en && (r_cnt == pre);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || !en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_cmp.sv
// timer_cmp -- free-running CNT_W-bit counter with N_CMP compare channels.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   addr      : word address (COUNT_LO/HI, CTRL, STATUS, CMPk_LO/HI)
//   read      : read strobe; readdata updates on the next edge
//   write     : write strobe
//   writedata : write data
//   readdata  : registered read data, holds between reads
//   irq       : per-channel level interrupt, registered PEND & IE
module timer_cmp
  import timer_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int N_CMP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       addr,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [N_CMP-1:0] irq
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] r_count;
  logic [HI_W-1:0]  r_shadow;
  logic             r_en;
  logic [N_CMP-1:0] r_ie;
  logic [PRE_W-1:0] r_pre;
  logic [N_CMP-1:0] r_pend;
  logic [N_CMP-1:0] r_irq;
  logic [31:0]      r_rdata;

  logic             w_tick;
  logic             w_wr_lo;
  logic             w_wr_hi;
  logic             w_wr_ctrl;
  logic [N_CMP-1:0] w_clr;
  logic [N_CMP-1:0] w_match;
  logic [CNT_W-1:0] w_cmp [N_CMP];
  logic [31:0]      w_rdata;

  assign w_wr_lo   = write && (addr == REG_COUNT_LO);
  assign w_wr_hi   = write && (addr == REG_COUNT_HI);
  assign w_wr_ctrl = write && (addr == REG_CTRL);
  assign w_clr     = (write && (addr == REG_STATUS)) ?
                     writedata[STATUS_PEND_LSB +: N_CMP] : '0;

  // Any CTRL write rewrites PRE, so the divider restarts from 0.
  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (r_en),
    .pre  (r_pre),
    .clr  (w_wr_ctrl),
    .tick (w_tick)
  );

  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    logic [CNT_W-1:0] r_cmp;

    // NOTE: compare values are plain registers, not a memory array, so they
    // take a reset value (all-ones: never matches until software programs it).
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cmp <= '1;
      end else if (write && (addr == cmp_addr(k, 1'b0))) begin
        r_cmp[31:0] <= writedata;
      end else if (write && (addr == cmp_addr(k, 1'b1))) begin
        r_cmp[CNT_W-1:32] <= writedata[HI_W-1:0];
      end
    end

    assign w_cmp[k]   = r_cmp;
    assign w_match[k] = (r_count >= r_cmp);
  end

  // Read mux over pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    // NOTE: default every bit first so no path through the case leaves
    // w_rdata unassigned and infers a latch.
    w_rdata = '0;
    case (addr)
      REG_COUNT_LO: w_rdata = r_count[31:0];
      REG_COUNT_HI: w_rdata[HI_W-1:0] = r_shadow;
      REG_CTRL: begin
        w_rdata[CTRL_EN_BIT]               = r_en;
        w_rdata[CTRL_IE_LSB +: N_CMP]      = r_ie;
        w_rdata[CTRL_PRE_LSB +: PRE_W]     = r_pre;
      end
      REG_STATUS: w_rdata[STATUS_PEND_LSB +: N_CMP] = r_pend;
      default: begin
        for (int k = 0; k < N_CMP; k++) begin
          if (addr == cmp_addr(k, 1'b0)) begin
            w_rdata = w_cmp[k][31:0];
          end
          if (addr == cmp_addr(k, 1'b1)) begin
            w_rdata[HI_W-1:0] = w_cmp[k][CNT_W-1:32];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_shadow <= '0;
      r_en     <= 1'b1;
      r_ie     <= '0;
      r_pre    <= '0;
      r_pend   <= '0;
      r_irq    <= '0;
      r_rdata  <= '0;
    end else begin
      // A half-write wins over the tick for that cycle.
      if (w_wr_lo) begin
        r_count[31:0] <= writedata;
      end else if (w_wr_hi) begin
        r_count[CNT_W-1:32] <= writedata[HI_W-1:0];
      end else if (w_tick) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (w_wr_ctrl) begin
        r_en  <= writedata[CTRL_EN_BIT];
        r_ie  <= writedata[CTRL_IE_LSB +: N_CMP];
        r_pre <= writedata[CTRL_PRE_LSB +: PRE_W];
      end

      // Set has priority over W1C.
      r_pend <= w_match | (r_pend & ~w_clr);
      r_irq  <= r_pend & r_ie;

      if (read) begin
        r_rdata <= w_rdata;
        // Snapshot the upper half so a following HI read pairs with this LO.
        if (addr == REG_COUNT_LO) begin
          r_shadow <= r_count[CNT_W-1:32];
        end
      end
    end
  end

  assign readdata = r_rdata;
  assign irq      = r_irq;

endmodule

// File: doc/timer_cmp.md
TIMER_CMP -- requirements
Module: timer_cmp

Interface
REQ-001 SHALL have parameter CNT_W, default 64, counter width, legal range 33..64.
REQ-002 SHALL have parameter N_CMP, default 2, number of compare channels, legal range 1..6.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port addr  input  4  word address.
REQ-006 SHALL have port read  input  1  read strobe.
REQ-007 SHALL have port write  input  1  write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port irq  output  N_CMP  per-channel interrupt, level, registered.

Function
REQ-011 SHALL decode the map: 0 COUNT_LO, 1 COUNT_HI, 2 CTRL, 3 STATUS, 4+2k CMPk_LO, 5+2k CMPk_HI, for k < N_CMP.
REQ-012 SHALL lay out CTRL as: bit0 EN, bits 8+k IEk, bits 31:16 PRE; all other bits read 0 and ignore writes.
REQ-013 SHALL lay out STATUS as: bits k PENDk; a write of 1 clears the bit (W1C), a write of 0 has no effect.
REQ-014 SHALL have a prescaler counter that, when EN=1, emits a tick when it equals PRE and then returns to 0; otherwise it increments; PRE=0 ticks every cycle.
REQ-015 SHALL hold the prescaler counter at 0 when EN=0.
REQ-016 SHALL increment count by 1 on each tick, modulo 2^CNT_W; all-ones wraps to 0 with no side effect.
REQ-017 SHALL load a COUNT_LO/COUNT_HI write into that half; in that cycle the other half holds and no increment occurs.
REQ-018 SHALL ignore writedata bits above CNT_W-33 on HI writes; HI reads return 0 in those bits.
REQ-019 SHALL make a write to CTRL.PRE reset the prescaler counter to 0 in the same cycle.
REQ-020 SHALL have read latency 1: readdata updates on the clock edge after read=1 and otherwise holds its value.
REQ-021 SHALL latch count[CNT_W-1:32] into a shadow register on a COUNT_LO read; a COUNT_HI read returns the shadow, giving atomic LO-then-HI reads.
REQ-022 SHALL return 0 for reads of unmapped addresses, including compare slots with k >= N_CMP; writes to them SHALL be ignored.
REQ-023 SHALL define matchk = (count >= cmpk), unsigned, full CNT_W width, evaluated on the registered count.
REQ-024 SHALL set PENDk on any cycle in which matchk=1; set wins over a simultaneous W1C clear.
REQ-025 SHALL drive irq[k] registered = PENDk & IEk, i.e. one cycle after PENDk changes.
REQ-026 SHALL write CMPk_LO/HI halves independently; software writes HI = all-ones first to avoid spurious matches.
REQ-027 SHALL apply a simultaneous read and write to the same address as: read returns the pre-write value.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set: count 0, prescaler 0, shadow 0, EN=1, IE=0, PRE=0, PEND=0, cmpk all-ones, readdata 0, irq 0.
REQ-029 SHALL let reset mid-operation override any concurrent read or write in that cycle.
REQ-030 SHALL have count = 0 in the first cycle after reset deasserts and count = 1 in the following cycle (EN=1, PRE=0).

Structure
REQ-031 SHALL place register offsets, CTRL/STATUS bit positions and PRE width (16) as constants in package timer_pkg.
REQ-032 SHALL implement the prescaler as sub-module timer_prescaler (inputs en, pre, clr; output tick).
REQ-033 SHALL generate compare channels with a generate loop over N_CMP; there SHALL be no other sub-modules.

Verification
REQ-034 SHALL cover: reset released, PRE=0 -> COUNT_LO reads 0,1,2,... on consecutive cycles; irq=0.
REQ-035 SHALL cover: CTRL PRE=3 -> count advances once per 4 cycles; EN=0 -> count frozen.
REQ-036 SHALL cover: COUNT_LO=0xFFFFFFFF, COUNT_HI=0 -> HI becomes 1 after one tick; COUNT_HI=all-ones, LO=all-ones -> wraps to 0.
REQ-037 SHALL cover: CMP0=10, IE0=1 -> PEND0 set at count 10, irq[0] one cycle later; W1C while count>=10 -> PEND0 stays 1.
REQ-038 SHALL cover: LO read at count 0x1_FFFFFFFF, then HI read 3 cycles later -> HI returns 1, not 2.
REQ-039 SHALL cover: rst asserted during a CMP1 write -> CMP1 all-ones, PEND=0, readdata=0.
